regfile_wb_arbiter: RTL

- Owns the single write port of the 32x32 register file.
- Arbitrates two writeback requesters: requester 0 is the ALU result path, requester 1 is the load/LSU return path.
- Both use a valid/ready handshake.
- Keeps a pending-load scoreboard so the decode stage can stall on operands whose load has not returned.
- Orders ALU writes behind outstanding loads to the same register.
- Sits between execute/memory and the register file's DataD/AddressD/RegWriteEnable inputs.

---
 rtl/regfile_wb_arbiter_if.sv | 46 ++++
 rtl/regfile_wb_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execute/memory requesters and the
// register-file write arbiter. It carries the two writeback handshakes, the
// load reservation strobe and the decode operand busy lookups.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // Requester 0: ALU result path
  logic              ReqValid0;
  logic [ADDR_W-1:0] ReqAddr0;
  logic [DATA_W-1:0] ReqData0;
  logic              ReqReady0;
  // Requester 1: load/LSU return path
  logic              ReqValid1;
  logic [ADDR_W-1:0] ReqAddr1;
  logic [DATA_W-1:0] ReqData1;
  logic              ReqReady1;
  // Load issue reservation
  logic              ResvValid;
  logic [ADDR_W-1:0] ResvAddr;
  // Decode operand lookups
  logic [ADDR_W-1:0] AddressA;
  logic [ADDR_W-1:0] AddressB;
  logic              BusyA;
  logic              BusyB;

  modport master (
    output ReqValid0, ReqAddr0, ReqData0,
    input  ReqReady0,
    output ReqValid1, ReqAddr1, ReqData1,
    input  ReqReady1,
    output ResvValid, ResvAddr,
    output AddressA, AddressB,
    input  BusyA, BusyB
  );

  modport slave (
    input  ReqValid0, ReqAddr0, ReqData0,
    output ReqReady0,
    input  ReqValid1, ReqAddr1, ReqData1,
    output ReqReady1,
    input  ResvValid, ResvAddr,
    input  AddressA, AddressB,
    output BusyA, BusyB
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner. Round-robin arbitrates the ALU and load
// writeback requesters, registers the winning write into DataD/AddressD with a
// one-cycle strobe, and tracks outstanding loads in a pending scoreboard so
// decode can stall and ALU writes stay ordered behind loads to the same reg.
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_wb_arbiter_if.slave wb,
  output logic                RegWriteEnable,
  output logic [ADDR_W-1:0]   AddressD,
  output logic [DATA_W-1:0]   DataD,
  output logic [NUM_REGS-1:0] Pending
);

  localparam logic [ADDR_W-1:0]   ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [NUM_REGS-1:0] ONE_HOT0  = {{(NUM_REGS-1){1'b0}}, 1'b1};

  // Scoreboard, round-robin pointer (1 = requester 1 was granted last) and
  // write stage registers.
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic                elig0_s, elig1_s;
  logic                grant0_s, grant1_s;
  logic [NUM_REGS-1:0] set_s, clr_s;

  // Eligibility and round-robin grant; grants are forced low during reset.
  always_comb begin
    elig0_s  = wb.ReqValid0 &&
               ((wb.ReqAddr0 == ADDR_ZERO) || !pending_q[wb.ReqAddr0]);
    elig1_s  = wb.ReqValid1;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      // Tie: the side not granted last wins.
      grant0_s = last_q;
      grant1_s = !last_q;
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  assign wb.ReqReady0 = grant0_s;
  assign wb.ReqReady1 = grant1_s;

  // Scoreboard next state: load grant clears, reservation sets (set wins), reg 0 never pending.
  always_comb begin
    clr_s     = grant1_s ? (ONE_HOT0 << wb.ReqAddr1) : {NUM_REGS{1'b0}};
    set_s     = wb.ResvValid ? (ONE_HOT0 << wb.ResvAddr) : {NUM_REGS{1'b0}};
    pending_d = ((pending_q & ~clr_s) | set_s) & ~ONE_HOT0;
  end

  // Write stage next state and pointer update; writes to reg 0 are swallowed.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    last_d = last_q;
    if (grant0_s) begin
      last_d = 1'b0;
      if (wb.ReqAddr0 != ADDR_ZERO) begin
        we_d   = 1'b1;
        addr_d = wb.ReqAddr0;
        data_d = wb.ReqData0;
      end else begin
        we_d   = 1'b0;
      end
    end else if (grant1_s) begin
      last_d = 1'b1;
      if (wb.ReqAddr1 != ADDR_ZERO) begin
        we_d   = 1'b1;
        addr_d = wb.ReqAddr1;
        data_d = wb.ReqData1;
      end else begin
        we_d   = 1'b0;
      end
    end else begin
      we_d   = 1'b0;
    end
  end

  // State registers; reset discards reservations and any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= {NUM_REGS{1'b0}};
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= ADDR_ZERO;
      data_q    <= {DATA_W{1'b0}};
    end else begin
      pending_q <= pending_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign RegWriteEnable = we_q;
  assign AddressD       = addr_q;
  assign DataD          = data_q;
  assign Pending        = pending_q;

  // Operand busy lookups read the current scoreboard, so a load already in
  // the write stage no longer reports busy.
  assign wb.BusyA = pending_q[wb.AddressA];
  assign wb.BusyB = pending_q[wb.AddressB];

endmodule
